// File: rtl/ddr4_init_sequencer_pkg.sv
// Purpose: shared constants for the DDR4 power-up sequencer (command encodings, FSM states, MR order/payloads).
// Latency: n/a (package only).
// Backpressure: n/a.
package ddr4_init_sequencer_pkg;

    // Command pin encoding, packed as {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14}
    localparam logic [4:0] CMD_DES  = 5'b11111;
    localparam logic [4:0] CMD_MRS  = 5'b01000;
    localparam logic [4:0] CMD_ZQCL = 5'b01110;

    // Sequencer states. MRS and ZQCL are the single cycles in which that
    // command is on the pins; all other states drive DES.
    typedef logic [3:0] init_state_t;
    localparam init_state_t ST_RST_LOW  = 4'd0;
    localparam init_state_t ST_RST_REL  = 4'd1;
    localparam init_state_t ST_CKE_WAIT = 4'd2;
    localparam init_state_t ST_MRS      = 4'd3;
    localparam init_state_t ST_MRD_WAIT = 4'd4;
    localparam init_state_t ST_MOD_WAIT = 4'd5;
    localparam init_state_t ST_ZQCL     = 4'd6;
    localparam init_state_t ST_ZQ_WAIT  = 4'd7;
    localparam init_state_t ST_DONE     = 4'd8;

    // Mode-register write order: MR3, MR6, MR5, MR4, MR2, MR1, MR0.
    // Element [0] is issued first.
    localparam logic [2:0]      MR_LAST_IDX = 3'd6;
    localparam logic [6:0][2:0] MR_ORDER    = {3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd3};

    // Default MR payloads on A13..A0. MR0 A1:A0 is replaced by the burst mode.
    localparam logic [13:0] MR0_DEF = 14'h0210;
    localparam logic [13:0] MR1_DEF = 14'h0001;
    localparam logic [13:0] MR2_DEF = 14'h0008;
    localparam logic [13:0] MR3_DEF = 14'h0000;
    localparam logic [13:0] MR4_DEF = 14'h0000;
    localparam logic [13:0] MR5_DEF = 14'h0400;
    localparam logic [13:0] MR6_DEF = 14'h0800;

    // ZQCL: A10 high selects the long calibration.
    localparam logic [13:0] ZQCL_ADDR = 14'h0400;

    // Registered command/address bus
    typedef struct packed {
        logic [4:0]  cmd;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [13:0] addr;
    } ca_bus_t;

    localparam ca_bus_t CA_DES = {CMD_DES, 2'b00, 2'b00, 14'h0000};

    function automatic logic [13:0] mr_payload(input logic [2:0] mr);
        logic [13:0] p;
        case (mr)
            3'd0:    p = MR0_DEF;
            3'd1:    p = MR1_DEF;
            3'd2:    p = MR2_DEF;
            3'd3:    p = MR3_DEF;
            3'd4:    p = MR4_DEF;
            3'd5:    p = MR5_DEF;
            3'd6:    p = MR6_DEF;
            default: p = 14'h0000;
        endcase
        return p;
    endfunction

    // Full MRS pin image for one mode register. The MR number rides on
    // bg[0] (address bit 2) and ba (address bits 1:0).
    function automatic ca_bus_t mrs_cmd(input logic [2:0] mr, input logic bl_sel);
        ca_bus_t ca;
        ca.cmd  = CMD_MRS;
        ca.bg   = {1'b0, mr[2]};
        ca.ba   = mr[1:0];
        ca.addr = mr_payload(mr);
        if (mr == 3'd0) begin
            ca.addr[1:0] = {bl_sel, 1'b0};
        end
        return ca;
    endfunction

endpackage

// File: rtl/init_delay_counter.sv
// Purpose: loadable 16-bit down-counter shared by every wait state of the init sequencer.
// Latency: load takes effect on the next edge; zero flag is combinational from the count.
// Backpressure: none; the counter stops at zero until reloaded.
// Ports: i_clk/i_rst clock and async active-high reset, i_load/i_value load strobe and value,
//        o_zero high while the count is zero.
module init_delay_counter #(
    parameter logic [15:0] RST_VAL = 16'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [15:0] i_value,
    output logic        o_zero
);

    logic [15:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= RST_VAL;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != 16'd0) begin
            r_count <= r_count - 16'd1;
        end
    end

    assign o_zero = (r_count == 16'd0);

endmodule

// File: rtl/ddr4_init_sequencer.sv
// Purpose: drives DDR4 reset_n, CKE and CA pins through reset, CKE, 7x MRS, ZQCL, then flags init_done.
// Latency: all outputs registered; each action lands exactly N cycles after the previous one.
// Backpressure: none; free-running once reset releases, restarts on any reset.
// Ports: i_clock_t/i_reset clock and async reset, i_bl_sel burst mode (sampled at MR0),
//        o_reset_n/o_cke DRAM control, o_cs_n..o_we_n_a14/o_bg/o_ba/o_addr command bus,
//        o_init_done sequence complete.
module ddr4_init_sequencer
    import ddr4_init_sequencer_pkg::*;
#(
    parameter int T_RESET = 16,
    parameter int tCKE_L  = 10,
    parameter int tXPR    = 20,
    parameter int tMRD    = 8,
    parameter int tMOD    = 24,
    parameter int tZQ     = 512
) (
    input  logic        i_clock_t,
    input  logic        i_reset,
    input  logic        i_bl_sel,
    output logic        o_reset_n,
    output logic        o_cke,
    output logic        o_cs_n,
    output logic        o_act_n,
    output logic        o_ras_n_a16,
    output logic        o_cas_n_a15,
    output logic        o_we_n_a14,
    output logic [1:0]  o_bg,
    output logic [1:0]  o_ba,
    output logic [13:0] o_addr,
    output logic        o_init_done
);

    // A delay below 2 would let the counter hit zero inside a command
    // cycle, and anything above 65536 does not fit the counter.
    if (T_RESET < 2 || tCKE_L < 2 || tXPR < 2 || tMRD < 2 || tMOD < 2 || tZQ < 2 ||
        T_RESET > 65536 || tCKE_L > 65536 || tXPR > 65536 ||
        tMRD > 65536 || tMOD > 65536 || tZQ > 65536) begin : g_bad_delay
        $error("ddr4_init_sequencer: every delay parameter must be in 2..65536");
    end

    // Counter holds N-1 and the action fires on the edge where it reads 0.
    localparam logic [15:0] LD_RESET = 16'(T_RESET - 1);
    localparam logic [15:0] LD_CKE_L = 16'(tCKE_L - 1);
    localparam logic [15:0] LD_XPR   = 16'(tXPR - 1);
    localparam logic [15:0] LD_MRD   = 16'(tMRD - 1);
    localparam logic [15:0] LD_MOD   = 16'(tMOD - 1);
    localparam logic [15:0] LD_ZQ    = 16'(tZQ - 1);

    init_state_t r_state;
    logic [2:0]  r_mr_idx;
    logic        r_reset_n;
    logic        r_cke;
    ca_bus_t     r_ca;
    logic        r_init_done;

    init_state_t w_state_nxt;
    logic [2:0]  w_mr_idx_nxt;
    logic        w_reset_n_nxt;
    logic        w_cke_nxt;
    ca_bus_t     w_ca_nxt;
    logic        w_init_done_nxt;
    logic        w_load;
    logic [15:0] w_load_val;
    logic        w_cnt_zero;

    // Reset preloads the RST_LOW delay, so the first wait needs no load cycle.
    init_delay_counter #(
        .RST_VAL (LD_RESET)
    ) u_delay (
        .i_clk   (i_clock_t),
        .i_rst   (i_reset),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_zero  (w_cnt_zero)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_mr_idx_nxt    = r_mr_idx;
        w_reset_n_nxt   = r_reset_n;
        w_cke_nxt       = r_cke;
        w_ca_nxt        = CA_DES;
        w_init_done_nxt = r_init_done;
        w_load          = 1'b0;
        w_load_val      = 16'd0;

        case (r_state)
            ST_RST_LOW: begin
                if (w_cnt_zero) begin
                    w_reset_n_nxt = 1'b1;
                    w_load        = 1'b1;
                    w_load_val    = LD_CKE_L;
                    w_state_nxt   = ST_RST_REL;
                end
            end
            ST_RST_REL: begin
                if (w_cnt_zero) begin
                    w_cke_nxt   = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = LD_XPR;
                    w_state_nxt = ST_CKE_WAIT;
                end
            end
            ST_CKE_WAIT, ST_MRD_WAIT: begin
                if (w_cnt_zero) begin
                    w_ca_nxt    = mrs_cmd(MR_ORDER[r_mr_idx], i_bl_sel);
                    w_load      = 1'b1;
                    w_load_val  = (r_mr_idx == MR_LAST_IDX) ? LD_MOD : LD_MRD;
                    w_state_nxt = ST_MRS;
                end
            end
            ST_MRS: begin
                // Counter is still counting the delay loaded on the issue edge.
                if (r_mr_idx == MR_LAST_IDX) begin
                    w_state_nxt = ST_MOD_WAIT;
                end else begin
                    w_mr_idx_nxt = r_mr_idx + 3'd1;
                    w_state_nxt  = ST_MRD_WAIT;
                end
            end
            ST_MOD_WAIT: begin
                if (w_cnt_zero) begin
                    w_ca_nxt      = CA_DES;
                    w_ca_nxt.cmd  = CMD_ZQCL;
                    w_ca_nxt.addr = ZQCL_ADDR;
                    w_load        = 1'b1;
                    w_load_val    = LD_ZQ;
                    w_state_nxt   = ST_ZQCL;
                end
            end
            ST_ZQCL: begin
                w_state_nxt = ST_ZQ_WAIT;
            end
            ST_ZQ_WAIT: begin
                if (w_cnt_zero) begin
                    w_init_done_nxt = 1'b1;
                    w_state_nxt     = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_DONE;
            end
        endcase
    end

    always_ff @(posedge i_clock_t or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_RST_LOW;
            r_mr_idx    <= 3'd0;
            r_reset_n   <= 1'b0;
            r_cke       <= 1'b0;
            r_ca        <= CA_DES;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mr_idx    <= w_mr_idx_nxt;
            r_reset_n   <= w_reset_n_nxt;
            r_cke       <= w_cke_nxt;
            r_ca        <= w_ca_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    assign o_reset_n   = r_reset_n;
    assign o_cke       = r_cke;
    assign o_cs_n      = r_ca.cmd[4];
    assign o_act_n     = r_ca.cmd[3];
    assign o_ras_n_a16 = r_ca.cmd[2];
    assign o_cas_n_a15 = r_ca.cmd[1];
    assign o_we_n_a14  = r_ca.cmd[0];
    assign o_bg        = r_ca.bg;
    assign o_ba        = r_ca.ba;
    assign o_addr      = r_ca.addr;
    assign o_init_done = r_init_done;

endmodule

// File: tb/tb_ddr4_init_sequencer.sv
// Purpose: self-checking bench for ddr4_init_sequencer (milestone table, timeline model, async reset).
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_ddr4_init_sequencer;

    localparam int T_RESET = 16;
    localparam int T_CKE_L = 10;
    localparam int T_XPR   = 20;
    localparam int T_MRD   = 8;
    localparam int T_MOD   = 24;
    localparam int T_ZQ    = 512;
    localparam int RUN_LEN = 645;

    localparam logic [4:0] DES = 5'b11111;
    localparam logic [4:0] MRS = 5'b01000;
    localparam logic [4:0] ZQC = 5'b01110;

    typedef struct packed {
        logic        rn;
        logic        ck;
        logic [4:0]  cmd;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [13:0] addr;
        logic        done;
    } pins_t;

    typedef struct {
        int    cyc;
        int    bl_only;   // 0/1: only in the run holding that bl_sel, 2: any run
        pins_t exp;
        string name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bl  = 1'b0;
    logic        reset_n, cke, cs_n, act_n, ras_n, cas_n, we_n, init_done;
    logic [1:0]  bg, ba;
    logic [13:0] addr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit bl_hist [0:1023];
    vec_t vecs[$];

    int          mr_order [0:6] = '{3, 6, 5, 4, 2, 1, 0};
    logic [13:0] mr_pay   [0:6] = '{14'h0210, 14'h0001, 14'h0008, 14'h0000,
                                    14'h0000, 14'h0400, 14'h0800};

    always #5 clk = ~clk;

    ddr4_init_sequencer dut (
        .i_clock_t   (clk),
        .i_reset     (rst),
        .i_bl_sel    (bl),
        .o_reset_n   (reset_n),
        .o_cke       (cke),
        .o_cs_n      (cs_n),
        .o_act_n     (act_n),
        .o_ras_n_a16 (ras_n),
        .o_cas_n_a15 (cas_n),
        .o_we_n_a14  (we_n),
        .o_bg        (bg),
        .o_ba        (ba),
        .o_addr      (addr),
        .o_init_done (init_done)
    );

    function automatic pins_t mk(bit rn, bit ck, logic [4:0] cmd, logic [1:0] g,
                                 logic [1:0] b, logic [13:0] a, bit d);
        pins_t p;
        p.rn = rn; p.ck = ck; p.cmd = cmd; p.bg = g; p.ba = b; p.addr = a; p.done = d;
        return p;
    endfunction

    function automatic pins_t sample();
        return mk(reset_n, cke, {cs_n, act_n, ras_n, cas_n, we_n}, bg, ba, addr, init_done);
    endfunction

    // Timeline model: cycle c counts edges since reset release (c = 0 before the first edge).
    function automatic pins_t model(int c);
        pins_t p;
        int    t_mrs0;
        int    t_zq;
        t_mrs0 = T_RESET + T_CKE_L + T_XPR;
        t_zq   = t_mrs0 + 6 * T_MRD + T_MOD;
        p = mk(c >= T_RESET, c >= T_RESET + T_CKE_L, DES, 2'b00, 2'b00, 14'h0, c >= t_zq + T_ZQ);
        for (int k = 0; k < 7; k++) begin
            if (c == t_mrs0 + k * T_MRD) begin
                logic [2:0] mr;
                mr     = 3'(mr_order[k]);
                p.cmd  = MRS;
                p.bg   = {1'b0, mr[2]};
                p.ba   = mr[1:0];
                p.addr = mr_pay[mr];
                if (mr == 3'd0) p.addr[1:0] = {bl_hist[c - 1], 1'b0};
            end
        end
        if (c == t_zq) begin
            p.cmd  = ZQC;
            p.addr = 14'h0400;
        end
        return p;
    endfunction

    task automatic check(input string nm, input pins_t act, input pins_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic pick(int mode);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return mode[0];
    endfunction

    task automatic check_cycle(input int mode);
        pins_t s;
        s = sample();
        check("model", s, model(cyc));
        foreach (vecs[i]) begin
            if (vecs[i].cyc == cyc && (vecs[i].bl_only == 2 || vecs[i].bl_only == mode))
                check(vecs[i].name, s, vecs[i].exp);
        end
    endtask

    // mode: 0 hold bl_sel=0, 1 hold bl_sel=1, 2 random each cycle.
    // abort_at > 0: assert reset between edges at that cycle and stop.
    task automatic run_seq(input int mode, input int abort_at);
        rst = 1'b1;
        bl  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cyc = -1;
        check("reset_held", sample(), mk(0, 0, DES, 2'b00, 2'b00, 14'h0, 0));
        rst = 1'b0;
        cyc = 0;
        check_cycle(mode);
        bl = pick(mode);
        bl_hist[0] = bl;
        while (cyc < RUN_LEN) begin
            @(posedge clk);
            #1;
            cyc++;
            if (abort_at > 0 && cyc == abort_at) begin
                #2 rst = 1'b1;
                #1;
                check("async_reset", sample(), mk(0, 0, DES, 2'b00, 2'b00, 14'h0, 0));
                @(posedge clk);
                #1;
                check("reset_after_edge", sample(), mk(0, 0, DES, 2'b00, 2'b00, 14'h0, 0));
                return;
            end
            check_cycle(mode);
            bl = pick(mode);
            bl_hist[cyc] = bl;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{0,   2, mk(0, 0, DES, 2'b00, 2'b00, 14'h0000, 0), "reset_state"});
        vecs.push_back('{15,  2, mk(0, 0, DES, 2'b00, 2'b00, 14'h0000, 0), "reset_n_low_c15"});
        vecs.push_back('{16,  2, mk(1, 0, DES, 2'b00, 2'b00, 14'h0000, 0), "reset_n_rise_c16"});
        vecs.push_back('{25,  2, mk(1, 0, DES, 2'b00, 2'b00, 14'h0000, 0), "cke_low_c25"});
        vecs.push_back('{26,  2, mk(1, 1, DES, 2'b00, 2'b00, 14'h0000, 0), "cke_rise_c26"});
        vecs.push_back('{45,  2, mk(1, 1, DES, 2'b00, 2'b00, 14'h0000, 0), "des_before_mr3"});
        vecs.push_back('{46,  2, mk(1, 1, MRS, 2'b00, 2'b11, 14'h0000, 0), "mrs_mr3_c46"});
        vecs.push_back('{47,  2, mk(1, 1, DES, 2'b00, 2'b00, 14'h0000, 0), "des_after_mr3"});
        vecs.push_back('{54,  2, mk(1, 1, MRS, 2'b01, 2'b10, 14'h0800, 0), "mrs_mr6_c54"});
        vecs.push_back('{62,  2, mk(1, 1, MRS, 2'b01, 2'b01, 14'h0400, 0), "mrs_mr5_c62"});
        vecs.push_back('{70,  2, mk(1, 1, MRS, 2'b01, 2'b00, 14'h0000, 0), "mrs_mr4_c70"});
        vecs.push_back('{78,  2, mk(1, 1, MRS, 2'b00, 2'b10, 14'h0008, 0), "mrs_mr2_c78"});
        vecs.push_back('{86,  2, mk(1, 1, MRS, 2'b00, 2'b01, 14'h0001, 0), "mrs_mr1_c86"});
        vecs.push_back('{94,  1, mk(1, 1, MRS, 2'b00, 2'b00, 14'h0212, 0), "mrs_mr0_bc4"});
        vecs.push_back('{94,  0, mk(1, 1, MRS, 2'b00, 2'b00, 14'h0210, 0), "mrs_mr0_bl8"});
        vecs.push_back('{117, 2, mk(1, 1, DES, 2'b00, 2'b00, 14'h0000, 0), "des_before_zqcl"});
        vecs.push_back('{118, 2, mk(1, 1, ZQC, 2'b00, 2'b00, 14'h0400, 0), "zqcl_c118"});
        vecs.push_back('{629, 2, mk(1, 1, DES, 2'b00, 2'b00, 14'h0000, 0), "not_done_c629"});
        vecs.push_back('{630, 2, mk(1, 1, DES, 2'b00, 2'b00, 14'h0000, 1), "init_done_c630"});
        vecs.push_back('{644, 2, mk(1, 1, DES, 2'b00, 2'b00, 14'h0000, 1), "done_holds"});

        run_seq(1, 0);
        run_seq(0, 0);
        run_seq(2, 0);
        run_seq(0, 65);   // third MRS at 62, so cycle 65 sits in its tMRD wait
        run_seq(2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
